wb_port_arbiter: RTL

Shares the single register-file write port between the two result producers in the back end: the EX stage (ALU/mult results, stallable via valid/ready) and the LSU (load data, never stallable). LSU writes always win the port; EX writes that lose arbitration are held in a small in-order buffer and drained when the port is free. The block drives the registered register-file write port and reports pending-write hazards to ID so cross-source ordering is resolved upstream.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_skid_fifo.sv | 58 +++++
 rtl/wb_port_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package wb_pkg;

  localparam int unsigned WbDataWidth = 32;
  localparam int unsigned WbAddrWidth = 5;

  localparam logic [WbAddrWidth-1:0] RegX0 = '0;

  typedef struct packed {
    logic [WbAddrWidth-1:0] waddr;
    logic [WbDataWidth-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// In-order holding buffer for EX writes, exposing per-entry valid/address for hazard checks.
module wb_skid_fifo
  import wb_pkg::*;
#(
  parameter int unsigned BufDepth  = 2,
  parameter int unsigned AddrWidth = WbAddrWidth,
  parameter type         req_t     = wb_req_t
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 push_i,
  input  logic                                 pop_i,
  input  req_t                                 data_i,
  output req_t                                 head_o,
  output logic [$clog2(BufDepth):0]            count_o,
  output logic [BufDepth-1:0]                  entry_valid_o,
  output logic [BufDepth-1:0][AddrWidth-1:0]   entry_addr_o
);

  localparam int unsigned PtrW = $clog2(BufDepth);

  req_t            mem_q [BufDepth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // Entry i is live when its distance from the read pointer is below the count.
  always_comb begin
    entry_valid_o = '0;
    entry_addr_o  = '0;
    for (int i = 0; i < BufDepth; i++) begin
      logic [PtrW-1:0] off;
      off              = PtrW'(i) - rptr_q;
      entry_valid_o[i] = {1'b0, off} < count_q;
      entry_addr_o[i]  = mem_q[i].waddr;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: LSU always wins, EX writes are buffered in order,
// pending writes reported to ID as operand hazards.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DataWidth = WbDataWidth,
  parameter int unsigned AddrWidth = WbAddrWidth,
  parameter int unsigned BufDepth  = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ex_valid_i,
  output logic                       ex_ready_o,
  input  logic [AddrWidth-1:0]       ex_waddr_i,
  input  logic [DataWidth-1:0]       ex_wdata_i,
  input  logic                       lsu_valid_i,
  input  logic [AddrWidth-1:0]       lsu_waddr_i,
  input  logic [DataWidth-1:0]       lsu_wdata_i,
  input  logic [AddrWidth-1:0]       rs1_addr_i,
  input  logic [AddrWidth-1:0]       rs2_addr_i,
  output logic                       rs1_hazard_o,
  output logic                       rs2_hazard_o,
  output logic                       rf_we_o,
  output logic [AddrWidth-1:0]       rf_waddr_o,
  output logic [DataWidth-1:0]       rf_wdata_o,
  output logic [$clog2(BufDepth):0]  buf_count_o
);

  typedef struct packed {
    logic [AddrWidth-1:0] waddr;
    logic [DataWidth-1:0] wdata;
  } req_t;

  localparam logic [$clog2(BufDepth):0] FullCount = ($clog2(BufDepth)+1)'(BufDepth);

  req_t                               head;
  logic [BufDepth-1:0]                entry_valid;
  logic [BufDepth-1:0][AddrWidth-1:0] entry_addr;
  logic lsu_sel, ex_acc, buf_empty, pop, bypass, push;

  assign ex_ready_o = buf_count_o != FullCount;
  assign buf_empty  = buf_count_o == '0;
  assign lsu_sel    = lsu_valid_i && (lsu_waddr_i != AddrWidth'(RegX0));
  assign ex_acc     = ex_valid_i && ex_ready_o && (ex_waddr_i != AddrWidth'(RegX0));
  assign pop        = !lsu_sel && !buf_empty;
  assign bypass     = !lsu_sel && buf_empty && ex_acc;
  assign push       = ex_acc && !bypass;

  wb_skid_fifo #(
    .BufDepth (BufDepth),
    .AddrWidth(AddrWidth),
    .req_t    (req_t)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .pop_i        (pop),
    .data_i       ('{waddr: ex_waddr_i, wdata: ex_wdata_i}),
    .head_o       (head),
    .count_o      (buf_count_o),
    .entry_valid_o(entry_valid),
    .entry_addr_o (entry_addr)
  );

  // Address/data hold their last value when no source is selected.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else if (lsu_sel) begin
      rf_we_o    <= 1'b1;
      rf_waddr_o <= lsu_waddr_i;
      rf_wdata_o <= lsu_wdata_i;
    end else if (pop) begin
      rf_we_o    <= 1'b1;
      rf_waddr_o <= head.waddr;
      rf_wdata_o <= head.wdata;
    end else if (bypass) begin
      rf_we_o    <= 1'b1;
      rf_waddr_o <= ex_waddr_i;
      rf_wdata_o <= ex_wdata_i;
    end else begin
      rf_we_o    <= 1'b0;
    end
  end

  always_comb begin
    logic m1, m2;
    m1 = rf_we_o && (rf_waddr_o == rs1_addr_i);
    m2 = rf_we_o && (rf_waddr_o == rs2_addr_i);
    for (int i = 0; i < BufDepth; i++) begin
      m1 = m1 || (entry_valid[i] && (entry_addr[i] == rs1_addr_i));
      m2 = m2 || (entry_valid[i] && (entry_addr[i] == rs2_addr_i));
    end
    rs1_hazard_o = m1 && (rs1_addr_i != AddrWidth'(RegX0));
    rs2_hazard_o = m2 && (rs2_addr_i != AddrWidth'(RegX0));
  end

endmodule
